// File: rtl/md_issue_ctrl.sv
// md_issue_ctrl
//
// Issue and interlock controller sitting between the D/E pipeline registers
// and the multiply/divide unit (MDU).
//   - Converts an E-stage mult/multu/div/divu into exactly one MDU start
//     pulse, no matter how many cycles the instruction sits in E.
//   - Stalls D while an HI/LO-class instruction would collide with an MDU
//     operation that has been started and not yet finished.
//   - Keeps saturating issue/stall counters and a sticky protocol-error flag.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   e_valid      E register holds a real instruction
//   e_mdu_op     MDU opcode of the E instruction (0 none, 1..4 start ops,
//                5..8 mfhi/mflo/mthi/mtlo)
//   e_advance    E register loads a new instruction at the next edge
//   d_uses_md    D instruction is an MDU-class instruction
//   mdu_busy     MDU busy-or-start indication
//   mdu_start    one-cycle start pulse to the MDU
//   mdu_op_out   opcode presented to the MDU
//   stall_d      freeze F/D and insert a bubble into E
//   issue_cnt    saturating count of start pulses
//   stall_cnt    saturating count of stall_d cycles
//   proto_err    sticky: a start op reached E while an operation was in flight
//
// Start/busy handshake: mdu_start is a single-cycle request with no ready
// back-pressure; the MDU must accept it in that cycle. From the start edge the
// controller treats the operation as in flight until the first edge at which
// the MDU reports mdu_busy=0 and no new start is being issued. mdu_busy never
// feeds mdu_start, so the request path has no combinational loop.

module md_issue_ctrl #(
    parameter logic [4:0] MUL_OP_MIN = 5'd1,
    parameter logic [4:0] OP_NONE    = 5'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        e_valid,
    input  logic [4:0]  e_mdu_op,
    input  logic        e_advance,
    input  logic        d_uses_md,
    input  logic        mdu_busy,
    output logic        mdu_start,
    output logic [4:0]  mdu_op_out,
    output logic        stall_d,
    output logic [31:0] issue_cnt,
    output logic [31:0] stall_cnt,
    output logic        proto_err
);

    // Start ops occupy four consecutive codes from MUL_OP_MIN; the four
    // HI/LO move ops follow immediately after them.
    localparam logic [4:0] MUL_OP_MAX  = MUL_OP_MIN + 5'd3;
    localparam logic [4:0] HILO_OP_MIN = MUL_OP_MIN + 5'd4;
    localparam logic [4:0] HILO_OP_MAX = MUL_OP_MIN + 5'd7;

    logic is_start;
    logic is_hilo;
    // issued: the instruction currently in E already produced its pulse.
    logic issued;
    // in_flight: an MDU operation was started and has not been seen idle.
    logic in_flight;

    always_comb begin
        is_start   = e_valid && (e_mdu_op >= MUL_OP_MIN) && (e_mdu_op <= MUL_OP_MAX);
        is_hilo    = (e_mdu_op >= HILO_OP_MIN) && (e_mdu_op <= HILO_OP_MAX);
        mdu_start  = is_start && !issued && !in_flight;
        // Start opcodes are only visible to the MDU in their start cycle so
        // a frozen E stage cannot be mistaken for a second request.
        mdu_op_out = OP_NONE;
        if (e_valid && (is_hilo || mdu_start)) begin
            mdu_op_out = e_mdu_op;
        end
        stall_d    = d_uses_md && (mdu_start || in_flight || mdu_busy);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            issued    <= 1'b0;
            in_flight <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            // A new E instruction always re-arms issue, even if the old one
            // pulsed in this very cycle.
            if (e_advance) begin
                issued <= 1'b0;
            end else if (mdu_start) begin
                issued <= 1'b1;
            end

            if (mdu_start) begin
                in_flight <= 1'b1;
            end else if (!mdu_busy) begin
                in_flight <= 1'b0;
            end

            // A fresh start op meeting an in-flight operation means the D
            // interlock was bypassed; the op is dropped when E advances.
            if (is_start && !issued && in_flight) begin
                proto_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            issue_cnt <= 32'd0;
            stall_cnt <= 32'd0;
        end else begin
            if (mdu_start && (issue_cnt != 32'hFFFF_FFFF)) begin
                issue_cnt <= issue_cnt + 32'd1;
            end
            if (stall_d && (stall_cnt != 32'hFFFF_FFFF)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Directed bench for md_issue_ctrl: a table of per-cycle vectors followed by
// hand-written protocol-error and reset-mid-operation sequences. A negedge
// monitor pairs every observed start pulse with the opcode queued by the
// stimulus.

module tb_md_issue_ctrl;

    logic        clk;
    logic        reset;
    logic        e_valid;
    logic [4:0]  e_mdu_op;
    logic        e_advance;
    logic        d_uses_md;
    logic        mdu_busy;
    logic        mdu_start;
    logic [4:0]  mdu_op_out;
    logic        stall_d;
    logic [31:0] issue_cnt;
    logic [31:0] stall_cnt;
    logic        proto_err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [4:0] exp_q[$];
    logic [4:0] mon_exp;

    md_issue_ctrl #(
        .MUL_OP_MIN (5'd1),
        .OP_NONE    (5'd0)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .e_valid    (e_valid),
        .e_mdu_op   (e_mdu_op),
        .e_advance  (e_advance),
        .d_uses_md  (d_uses_md),
        .mdu_busy   (mdu_busy),
        .mdu_start  (mdu_start),
        .mdu_op_out (mdu_op_out),
        .stall_d    (stall_d),
        .issue_cnt  (issue_cnt),
        .stall_cnt  (stall_cnt),
        .proto_err  (proto_err)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- vector table ----------------
    typedef struct {
        logic        ev;
        logic [4:0]  op;
        logic        adv;
        logic        dum;
        logic        busy;
        logic        x_start;
        logic [4:0]  x_op;
        logic        x_stall;
        logic [31:0] x_icnt;
        logic [31:0] x_scnt;
    } vec_t;

    vec_t vecs[32];
    int   nv = 0;

    task automatic add_vec(input logic ev, input logic [4:0] op, input logic adv,
                           input logic dum, input logic busy, input logic x_start,
                           input logic [4:0] x_op, input logic x_stall,
                           input logic [31:0] x_icnt, input logic [31:0] x_scnt);
        vecs[nv] = '{ev, op, adv, dum, busy, x_start, x_op, x_stall, x_icnt, x_scnt};
        nv++;
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic ev, input logic [4:0] op, input logic adv,
                         input logic dum, input logic busy);
        e_valid   = ev;
        e_mdu_op  = op;
        e_advance = adv;
        d_uses_md = dum;
        mdu_busy  = busy;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (reset === 1'b1 && mdu_start === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_start: got op %0h expected no start", mdu_op_out);
            end else begin
                mon_exp = exp_q.pop_front();
                check("sb_start_op", 32'(mdu_op_out), 32'(mon_exp));
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b0;
        drive(1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        #3;
        check("rst_start",     32'(mdu_start),  32'd0);
        check("rst_op",        32'(mdu_op_out), 32'd0);
        check("rst_stall",     32'(stall_d),    32'd0);
        check("rst_issue_cnt", issue_cnt,       32'd0);
        check("rst_stall_cnt", stall_cnt,       32'd0);
        check("rst_proto",     32'(proto_err),  32'd0);
        tick();
        tick();
        reset = 1'b1;

        //       ev op    adv dum busy | start op    stall icnt scnt
        // single mult, busy follows
        add_vec(1, 5'd1, 1, 0, 0,   1, 5'd1, 0, 0, 0);
        add_vec(0, 5'd0, 0, 0, 1,   0, 5'd0, 0, 1, 0);
        add_vec(0, 5'd0, 0, 0, 1,   0, 5'd0, 0, 1, 0);
        add_vec(0, 5'd0, 0, 0, 1,   0, 5'd0, 0, 1, 0);
        add_vec(0, 5'd0, 0, 0, 1,   0, 5'd0, 0, 1, 0);
        add_vec(0, 5'd0, 0, 0, 0,   0, 5'd0, 0, 1, 0);
        add_vec(0, 5'd0, 0, 0, 0,   0, 5'd0, 0, 1, 0);
        // div frozen in E for six cycles
        add_vec(1, 5'd3, 0, 0, 0,   1, 5'd3, 0, 1, 0);
        add_vec(1, 5'd3, 0, 0, 1,   0, 5'd0, 0, 2, 0);
        add_vec(1, 5'd3, 0, 0, 1,   0, 5'd0, 0, 2, 0);
        add_vec(1, 5'd3, 0, 0, 1,   0, 5'd0, 0, 2, 0);
        add_vec(1, 5'd3, 0, 0, 1,   0, 5'd0, 0, 2, 0);
        add_vec(1, 5'd3, 0, 0, 1,   0, 5'd0, 0, 2, 0);
        add_vec(0, 5'd0, 1, 0, 1,   0, 5'd0, 0, 2, 0);
        add_vec(0, 5'd0, 0, 0, 0,   0, 5'd0, 0, 2, 0);
        add_vec(0, 5'd0, 0, 0, 0,   0, 5'd0, 0, 2, 0);
        // mult then dependent mfhi in D: 5 stall cycles
        add_vec(1, 5'd1, 1, 1, 1,   1, 5'd1, 1, 2, 0);
        add_vec(0, 5'd0, 0, 1, 1,   0, 5'd0, 1, 3, 1);
        add_vec(0, 5'd0, 0, 1, 1,   0, 5'd0, 1, 3, 2);
        add_vec(0, 5'd0, 0, 1, 1,   0, 5'd0, 1, 3, 3);
        add_vec(0, 5'd0, 0, 1, 0,   0, 5'd0, 1, 3, 4);
        add_vec(0, 5'd0, 1, 1, 0,   0, 5'd0, 0, 3, 5);
        add_vec(1, 5'd5, 1, 0, 0,   0, 5'd5, 0, 3, 5);
        // HI/LO passthrough, busy-only stall, gated opcodes
        add_vec(1, 5'd7, 0, 1, 0,   0, 5'd7, 0, 3, 5);
        add_vec(1, 5'd8, 1, 1, 0,   0, 5'd8, 0, 3, 5);
        add_vec(0, 5'd7, 1, 1, 1,   0, 5'd0, 1, 3, 5);
        add_vec(0, 5'd1, 0, 0, 0,   0, 5'd0, 0, 3, 6);
        add_vec(1, 5'd6, 1, 0, 0,   0, 5'd6, 0, 3, 6);

        for (int i = 0; i < nv; i++) begin
            drive(vecs[i].ev, vecs[i].op, vecs[i].adv, vecs[i].dum, vecs[i].busy);
            if (vecs[i].x_start) exp_q.push_back(vecs[i].x_op);
            @(negedge clk);
            check($sformatf("vec%0d_start", i), 32'(mdu_start),  32'(vecs[i].x_start));
            check($sformatf("vec%0d_op", i),    32'(mdu_op_out), 32'(vecs[i].x_op));
            check($sformatf("vec%0d_stall", i), 32'(stall_d),    32'(vecs[i].x_stall));
            check($sformatf("vec%0d_icnt", i),  issue_cnt,       vecs[i].x_icnt);
            check($sformatf("vec%0d_scnt", i),  stall_cnt,       vecs[i].x_scnt);
            tick();
        end
        check("tbl_issue_cnt", issue_cnt,      32'd3);
        check("tbl_stall_cnt", stall_cnt,      32'd6);
        check("tbl_proto",     32'(proto_err), 32'd0);

        // ---- protocol error: multu forced into E while divu in flight ----
        drive(1'b1, 5'd4, 1'b1, 1'b0, 1'b0);
        exp_q.push_back(5'd4);
        @(negedge clk);
        check("pe_divu_start", 32'(mdu_start), 32'd1);
        tick();
        drive(1'b1, 5'd2, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        check("pe_multu_start", 32'(mdu_start),  32'd0);
        check("pe_multu_op",    32'(mdu_op_out), 32'd0);
        check("pe_proto_pre",   32'(proto_err),  32'd0);
        tick();
        drive(1'b1, 5'd2, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        check("pe_multu_start2", 32'(mdu_start), 32'd0);
        check("pe_proto_set",    32'(proto_err), 32'd1);
        tick();
        drive(1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        repeat (100) tick();
        check("pe_proto_sticky", 32'(proto_err), 32'd1);
        check("pe_issue_cnt",    issue_cnt,       32'd4);
        reset = 1'b0;
        #1;
        check("pe_proto_async_clr", 32'(proto_err), 32'd0);
        check("pe_icnt_async_clr",  issue_cnt,       32'd0);
        check("pe_scnt_async_clr",  stall_cnt,       32'd0);
        tick();
        reset = 1'b1;
        @(negedge clk);
        check("pe_proto_after_rel", 32'(proto_err), 32'd0);
        tick();

        // ---- reset two cycles after a div start, div still in E ----
        drive(1'b1, 5'd3, 1'b0, 1'b1, 1'b0);
        exp_q.push_back(5'd3);
        @(negedge clk);
        check("rm_start",  32'(mdu_start), 32'd1);
        check("rm_stall0", 32'(stall_d),   32'd1);
        tick();
        drive(1'b1, 5'd3, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        check("rm_no_restart", 32'(mdu_start), 32'd0);
        check("rm_icnt1",      issue_cnt,       32'd1);
        tick();
        reset = 1'b0;
        #1;
        check("rm_icnt_clr",    issue_cnt,       32'd0);
        check("rm_scnt_clr",    stall_cnt,       32'd0);
        check("rm_proto_clr",   32'(proto_err),  32'd0);
        check("rm_flags_clr",   32'(mdu_start),  32'd1);
        tick();
        reset = 1'b1;
        drive(1'b1, 5'd3, 1'b0, 1'b1, 1'b0);
        exp_q.push_back(5'd3);
        @(negedge clk);
        check("rm_reissue",     32'(mdu_start),  32'd1);
        check("rm_reissue_op",  32'(mdu_op_out), 32'd3);
        check("rm_icnt_rel",    issue_cnt,       32'd0);
        tick();
        drive(1'b1, 5'd3, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        check("rm_single_pulse", 32'(mdu_start),  32'd0);
        check("rm_op_gated",     32'(mdu_op_out), 32'd0);
        check("rm_icnt_after",   issue_cnt,       32'd1);
        check("rm_stall_busy",   32'(stall_d),    32'd1);
        tick();
        drive(1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
        tick();
        tick();

        check("sb_queue_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/md_issue_ctrl.md
# md_issue_ctrl

Issue and interlock controller between the D/E pipeline registers and the multiply/divide unit. It turns an E-stage mult/multu/div/divu into exactly one MDU start pulse, however long that instruction stays in E. It stalls the D stage while an HI/LO-class instruction would collide with an operation in flight. It also keeps saturating performance counters and a sticky protocol-error flag.

## Interface
- `MUL_OP_MIN`, default 5'd1: lowest MDU opcode that starts an operation. Start ops are mult=1, multu=2, div=3, divu=4.
- `OP_NONE`, default 5'd0: opcode driven to the MDU when no instruction is presented.
- `clk` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-low reset. Asserted when 0.
- `e_valid` in 1: the E-stage register holds a real instruction, not a bubble.
- `e_mdu_op` in 5: MDU opcode of the E instruction. 0=none, 1..4=mult/multu/div/divu, 5=mfhi, 6=mflo, 7=mthi, 8=mtlo.
- `e_advance` in 1: the E register loads a new instruction at the next edge.
- `d_uses_md` in 1: the D-stage instruction has opcode 1..8.
- `mdu_busy` in 1: MDU busy-or-start indication.
- `mdu_start` out 1: start pulse to the MDU.
- `mdu_op_out` out 5: opcode to the MDU.
- `stall_d` out 1: freeze the F/D stages and insert a bubble into E.
- `issue_cnt` out 32: number of start pulses issued; saturates at 32'hFFFFFFFF.
- `stall_cnt` out 32: number of cycles with `stall_d`=1; saturates.
- `proto_err` out 1: sticky protocol-error flag.

## Operation
- `is_start` = `e_valid` & (`e_mdu_op` in 1..4).
- **Internal `issued` flag**
  - Set at an edge where `mdu_start`=1 and `e_advance`=0.
  - Cleared at any edge with `e_advance`=1.
  - If both conditions hold, `e_advance` wins and the flag clears.
- **Internal `in_flight` flag**
  - Set at an edge where `mdu_start`=1.
  - Cleared at the first edge where `mdu_busy`=0 and `mdu_start`=0.
- `mdu_start` = `is_start` & ~`issued` & ~`in_flight`. Combinational.
- **`mdu_op_out`**
  - Equals `e_mdu_op` when `e_valid`=1 and either the op is 5..8 or `mdu_start`=1.
  - Otherwise equals `OP_NONE`.
  - Start opcodes never reach the MDU except in their start cycle.
- `stall_d` = `d_uses_md` & (`mdu_start` | `in_flight` | `mdu_busy`). Combinational.
- **`proto_err`**
  - Set, and held until reset, when `is_start`=1, `issued`=0 and `in_flight`=1. This means a new start op reached E while an operation was in flight, which the D interlock should prevent.
  - In that case `mdu_start` stays 0 and the instruction is dropped when E advances.
- **Counters**
  - `issue_cnt` increments at each edge with `mdu_start`=1.
  - `stall_cnt` increments at each edge with `stall_d`=1.
  - Both hold at all-ones.
- **Reset (`reset`=0, any time, including mid-operation)**
  - `issued`, `in_flight`, `proto_err` and both counters go to 0 immediately.
  - Outputs are combinational from the state, so `mdu_start` and `stall_d` follow the inputs with cleared state.
  - The MDU is reset by the same system reset and is not otherwise informed.

## Timing
- `mdu_start` asserts in the same cycle the start op first appears valid in E, with zero-cycle latency from `e_valid`/`e_mdu_op`.
- It is never high for two consecutive cycles on the same instruction.
- `stall_d` rises in the start cycle if `d_uses_md`=1.
- `stall_d` stays high through every cycle `mdu_busy`=1.
- `stall_d` falls in the first cycle where `mdu_busy`=0 and `in_flight`=0. That is one cycle after MDU busy falls, because `in_flight` clears on the edge.
- Back-to-back case: when `issued` clears and `e_advance` brings a new start op in the same cycle, the new op issues in the next cycle only if `in_flight`=0.
- There are no combinational paths from `mdu_start` back into itself. `mdu_busy` affects only `stall_d` and `in_flight`.
- **Output reset values:** `mdu_start` 0 when `e_valid`=0, `mdu_op_out`=`OP_NONE`, `stall_d`=0 when `d_uses_md`=0, counters 0, `proto_err` 0.

## Test plan
- **Single mult.** E holds mult(1) for 1 cycle with `e_advance`=1, `d_uses_md`=0, and `mdu_busy` high 4 cycles after. Expect `mdu_start`=1 for exactly 1 cycle, `mdu_op_out`=1 only in that cycle, and `issue_cnt`=1.
- **Frozen E.** div(3) held in E for 6 cycles with `e_advance`=0. Expect one start pulse, `mdu_op_out`=0 in cycles 2-6, `issue_cnt`=1, and `proto_err`=0.
- **Dependent mfhi.** mult in E, then D holds mfhi (`d_uses_md`=1) while `mdu_busy` is high 4 cycles. Expect `stall_d`=1 for 5 cycles (start, 4 busy cycles minus overlap, plus the 1-cycle `in_flight` tail) and `stall_cnt`=5.
- **mthi passthrough with no op in flight.** E holds mthi(7). Expect `mdu_op_out`=7, `mdu_start`=0, and `stall_d`=0 even with `d_uses_md`=1.
- **Protocol error.** Issue divu, then force multu into E with `e_valid`=1 while `mdu_busy`=1. Expect no second start, `proto_err`=1, still 1 after 100 cycles, and cleared only by `reset`=0.
- **Reset mid-operation.** Assert `reset`=0 for 1 cycle two cycles after a div start. Expect `in_flight`, both counters and `proto_err` all 0 asynchronously, and the same div re-issues on release if it is still in E.
